// File: rtl/sr_latch_driver_pkg.sv
// Shared types and helpers for the SR latch driver: FSM encoding, opcodes,
// counter width and the pass/fail rule applied to the sampled latch outputs.
package sr_latch_driver_pkg;

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        SrdIdle   = 2'd0,
        SrdPulse  = 2'd1,
        SrdSettle = 2'd2,
        SrdCheck  = 2'd3
    } srd_state_e;

    localparam logic SrdOpSet = 1'b1;
    localparam logic SrdOpClr = 1'b0;

    // A healthy latch shows q == op and complementary outputs.
    function automatic logic check_fail(logic op, logic q, logic qn);
        return (q != op) || (q == qn);
    endfunction

    function automatic logic [CntW-1:0] sat_inc(logic [CntW-1:0] v);
        return (v == CntMax) ? v : v + CntW'(1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake and result signals between a sequencer and the latch driver.
interface sr_latch_driver_if;
    import sr_latch_driver_pkg::*;

    logic            cmd_valid;
    logic            cmd_op;
    logic            cmd_ready;
    logic            done;
    logic            err;
    logic [CntW-1:0] err_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready,
        input  done,
        input  err,
        input  err_count
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready,
        output done,
        output err,
        output err_count
    );

endinterface

// File: rtl/sr_latch_driver_pulse_timer.sv
// Loadable down-counter that stops at zero; times the pulse and settle windows.
module pulse_timer
    import sr_latch_driver_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CntW-1:0] load_value,
    output logic [CntW-1:0] value,
    output logic            zero
);

    logic [CntW-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (value_q != '0) begin
            value_d = value_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives non-overlapping set/reset pulses into an SR latch, waits a settle window,
// then checks the latch outputs and keeps a saturating count of failed checks.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   cmd,
    output logic               latch_set,
    output logic               latch_reset,
    input  logic               q_in,
    input  logic               qn_in
);

    localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE_W - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

    srd_state_e      state_q, state_d;
    logic            op_q, op_d;
    logic            accept;
    logic            cmd_ready;
    logic            timer_load;
    logic [CntW-1:0] timer_load_value;
    logic [CntW-1:0] timer_value;
    logic            timer_zero;
    logic            unused_timer;

    logic            latch_set_q, latch_reset_q;
    logic            done_q, err_q;
    logic [CntW-1:0] err_count_q;

    assign accept       = cmd.cmd_valid && cmd_ready;
    assign unused_timer = ^timer_value;

    pulse_timer u_pulse_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SrdIdle;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SrdIdle:   if (accept) state_d = SrdPulse;
            SrdPulse:  if (timer_zero) state_d = SrdSettle;
            SrdSettle: if (timer_zero) state_d = SrdCheck;
            SrdCheck:  state_d = SrdIdle;
            default:   state_d = SrdIdle;
        endcase
    end

    always_comb begin
        cmd_ready        = (state_q == SrdIdle);
        op_d             = op_q;
        timer_load       = 1'b0;
        timer_load_value = PulseLoad;
        if (accept) begin
            op_d       = cmd.cmd_op;
            timer_load = 1'b1;
        end else if ((state_q == SrdPulse) && timer_zero) begin
            timer_load       = 1'b1;
            timer_load_value = SettleLoad;
        end
    end

    // Pins are registered from the next state so they rise on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_set_q   <= 1'b0;
            latch_reset_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            latch_set_q   <= (state_d == SrdPulse) && (op_d == SrdOpSet);
            latch_reset_q <= (state_d == SrdPulse) && (op_d == SrdOpClr);
            done_q        <= (state_q == SrdCheck);
            if (state_q == SrdCheck) begin
                err_q <= check_fail(op_q, q_in, qn_in);
                if (check_fail(op_q, q_in, qn_in)) begin
                    err_count_q <= sat_inc(err_count_q);
                end
            end
        end
    end

    assign cmd.cmd_ready = cmd_ready;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;
    assign cmd.err_count = err_count_q;
    assign latch_set     = latch_set_q;
    assign latch_reset   = latch_reset_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed and randomized bench for sr_latch_driver with a behavioural latch and
// a reference model of expected pulse timing, check results and error count.
module tb_sr_latch_driver;

    localparam int PW = 2;
    localparam int ST = 2;

    logic clk;
    logic rst;
    logic latch_set, latch_reset;
    logic q_in, qn_in;

    sr_latch_driver_if bus ();

    sr_latch_driver #(
        .PULSE_W (PW),
        .SETTLE  (ST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (bus.slave),
        .latch_set   (latch_set),
        .latch_reset (latch_reset),
        .q_in        (q_in),
        .qn_in       (qn_in)
    );

    int   total;
    int   bad;
    int   exp_cnt;
    int   mode;   // 0: working latch, 1: outputs forced to fq/fqn
    logic lq;
    logic fq, fqn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural NOR latch, sampled synchronously.
    always @(posedge clk) begin
        if (latch_set && !latch_reset) lq <= 1'b1;
        else if (latch_reset && !latch_set) lq <= 1'b0;
    end

    assign q_in  = (mode == 0) ? lq  : fq;
    assign qn_in = (mode == 0) ? ~lq : fqn;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (!(latch_set && latch_reset)) else begin
                bad++;
                $error("FAIL overlap observed set=%0b reset=%0b expected not both", latch_set,
                       latch_reset);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check every cycle up to and including done.
    task automatic do_cmd(input logic op, input bit noise);
        int   k;
        logic eq, eqn, exp_err;
        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        eq      = (mode == 0) ? op  : fq;
        eqn     = (mode == 0) ? ~op : fqn;
        exp_err = (eq != op) || (eq == eqn);
        if (exp_err && exp_cnt < 255) exp_cnt++;
        @(negedge clk);
        for (int j = 0; j <= PW + ST + 1; j++) begin
            check("set_pin", 32'(latch_set), 32'((j < PW) && op));
            check("reset_pin", 32'(latch_reset), 32'((j < PW) && !op));
            check("done", 32'(bus.done), 32'(j == PW + ST + 1));
            check("ready", 32'(bus.cmd_ready), 32'(j == PW + ST + 1));
            if (j == PW + ST + 1) begin
                check("err", 32'(bus.err), 32'(exp_err));
                check("err_count", 32'(bus.err_count), 32'(exp_cnt));
            end else begin
                if (noise) begin
                    bus.cmd_op    = 1'($urandom);
                    bus.cmd_valid = (j < PW + ST - 1) ? 1'($urandom) : 1'b0;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int acc[4];
        int n;
        int c;
        total = 0;
        bad = 0;
        exp_cnt = 0;
        mode = 0;
        lq = 1'b0;
        fq = 1'b0;
        fqn = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_set", 32'(latch_set), 0);
        check("rst_reset", 32'(latch_reset), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_count", 32'(bus.err_count), 0);

        // Set then clear through the working latch.
        do_cmd(1'b1, 1'b0);
        check("set_q", 32'(q_in), 1);
        do_cmd(1'b0, 1'b0);
        check("clr_q", 32'(q_in), 0);
        check("clr_qn", 32'(qn_in), 1);

        // Stuck latch: both set commands must fail.
        mode = 1; fq = 1'b0; fqn = 1'b1;
        do_cmd(1'b1, 1'b0);
        do_cmd(1'b1, 1'b0);

        // Held valid with alternating op: accepts every PW+ST+2 cycles.
        mode = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 1'b1;
        n = 0;
        c = 0;
        while (n < 4 && c < 40) begin
            if (bus.cmd_ready) begin
                acc[n] = c;
                n++;
                @(negedge clk);
                bus.cmd_op = ~bus.cmd_op;
            end else begin
                @(negedge clk);
            end
            c++;
        end
        bus.cmd_valid = 1'b0;
        check("b2b_count", n, 4);
        for (int i = 1; i < 4; i++) check("b2b_period", acc[i] - acc[i-1], PW + ST + 2);
        repeat (PW + ST + 2) @(negedge clk);
        check("b2b_q", 32'(q_in), 0);
        check("b2b_err", 32'(bus.err), 0);
        check("b2b_count_err", 32'(bus.err_count), 32'(exp_cnt));

        // Reset during the second pulse cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_set_pin", 32'(latch_set), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("mid_set", 32'(latch_set), 0);
        check("mid_reset", 32'(latch_reset), 0);
        check("mid_ready", 32'(bus.cmd_ready), 1);
        check("mid_count", 32'(bus.err_count), 0);
        for (int i = 0; i < 8; i++) begin
            check("mid_no_done", 32'(bus.done), 0);
            @(negedge clk);
        end

        // Random commands, latch health and gaps, with ignored noise mid-flight.
        for (int i = 0; i < 20; i++) begin
            mode = int'($urandom_range(0, 1));
            fq   = 1'($urandom);
            fqn  = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_cmd(1'($urandom), 1'b1);
        end

        // Outputs stuck equal until the counter saturates.
        mode = 1; fq = 1'b1; fqn = 1'b1;
        for (int i = 0; i < 258; i++) do_cmd(1'($urandom), 1'b0);
        check("sat_count", 32'(bus.err_count), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
